// File: rtl/mbs_fsk_core.sv
// mbs_fsk_core: 5-bit m-sequence generator FSK-modulated onto a square wave, paced by a symbol counter
module mbs_fsk_core #(
    parameter int                LFSR_W     = 5,
    parameter logic [LFSR_W-1:0] SEED       = 5'b00001,
    parameter int                CNT_W      = 7,
    parameter int                BIT_PERIOD = 128,
    parameter int                HALF0      = 8,
    parameter int                HALF1      = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              en,
    output logic              ready,
    output logic              shift,
    output logic [LFSR_W-1:0] lfsr,
    output logic [CNT_W-1:0]  count,
    output logic              data_out,
    output logic              fsk_out
);
    localparam int TW = $clog2((HALF0 > HALF1 ? HALF0 : HALF1) + 1);
    logic [TW-1:0]     tone;
    logic [TW-1:0]     half_m1;
    logic              wrap;
    logic              hit;
    logic [LFSR_W-1:0] lfsr_nxt;
    assign data_out = lfsr[LFSR_W-1];
    // an all-zero register would lock up, so it recovers to SEED on the next advance
    always_comb begin
        wrap     = count == CNT_W'(BIT_PERIOD - 1);
        half_m1  = data_out ? TW'(HALF1 - 1) : TW'(HALF0 - 1);
        hit      = tone == half_m1;
        lfsr_nxt = lfsr == '0 ? SEED : {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-3]};
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ready   <= 1'b0;
            shift   <= 1'b0;
            lfsr    <= SEED;
            count   <= '0;
            tone    <= '0;
            fsk_out <= 1'b0;
        end else begin
            ready <= en;
            shift <= en && wrap;
            if (en) begin
                count   <= wrap ? '0 : count + CNT_W'(1);
                tone    <= (wrap || hit) ? '0 : tone + TW'(1);
                fsk_out <= fsk_out ^ hit;
                if (wrap) lfsr <= lfsr_nxt;
            end
        end
    end
endmodule

// File: tb/tb_mbs_fsk_core.sv
// tb_mbs_fsk_core: directed checks of counter pacing, m-sequence, FSK tones, freeze and lock-up recovery
module tb_mbs_fsk_core;
    logic       clk = 1'b0;
    logic       rstb;
    logic       en;
    logic       ready;
    logic       shift;
    logic [4:0] lfsr;
    logic [6:0] count;
    logic       data_out;
    logic       fsk_out;
    int         errors = 0;
    int         checks = 0;

    mbs_fsk_core dut (
        .clk(clk), .rstb(rstb), .en(en), .ready(ready), .shift(shift),
        .lfsr(lfsr), .count(count), .data_out(data_out), .fsk_out(fsk_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [4:0] nxt(input logic [4:0] s);
        return s == 5'd0 ? 5'h01 : {s[3:0], s[4] ^ s[2]};
    endfunction

    initial begin
        logic [4:0] m;
        bit         seen [32];
        int         distinct;
        rstb = 1'b0;
        en   = 1'b0;
        tick(2);
        chk("rst_lfsr", lfsr, 5'h01);
        chk("rst_count", count, 0);
        chk("rst_shift", shift, 0);
        chk("rst_ready", ready, 0);
        chk("rst_fsk", fsk_out, 0);
        chk("rst_data", data_out, 0);
        rstb = 1'b1;
        en   = 1'b1;
        tick(1);
        chk("rel_ready", ready, 1);
        chk("rel_count", count, 1);
        tick(6);
        chk("fsk_c7", fsk_out, 0);
        tick(1);
        chk("fsk_c8", fsk_out, 1);
        tick(8);
        chk("fsk_c16", fsk_out, 0);
        tick(111);
        chk("c127_count", count, 127);
        chk("c127_shift", shift, 0);
        chk("c127_lfsr", lfsr, 5'h01);
        chk("c127_fsk", fsk_out, 1);
        tick(1);
        chk("wrap_count", count, 0);
        chk("wrap_shift", shift, 1);
        chk("wrap_lfsr", lfsr, 5'h02);
        chk("wrap_fsk", fsk_out, 0);
        tick(1);
        chk("post_shift", shift, 0);
        chk("post_count", count, 1);
        tick(127);
        chk("seq_04", lfsr, 5'h04);
        chk("seq_04_shift", shift, 1);
        tick(128);
        chk("seq_09", lfsr, 5'h09);
        tick(128);
        chk("seq_12", lfsr, 5'h12);
        chk("seq_12_data", data_out, 1);
        chk("f1_e0", fsk_out, 0);
        tick(3);
        chk("f1_e3", fsk_out, 0);
        tick(1);
        chk("f1_e4", fsk_out, 1);
        tick(4);
        chk("f1_e8", fsk_out, 0);
        tick(4);
        chk("f1_e12", fsk_out, 1);
        tick(116);
        chk("seq_05", lfsr, 5'h05);
        chk("seq_05_shift", shift, 1);
        chk("seq_05_data", data_out, 0);
        chk("seq_05_fsk", fsk_out, 0);
        tick(128);
        chk("seq_0b", lfsr, 5'h0B);
        tick(50);
        chk("frz_count0", count, 50);
        en = 1'b0;
        tick(1);
        chk("frz_ready", ready, 0);
        chk("frz_count1", count, 50);
        tick(19);
        chk("frz_count", count, 50);
        chk("frz_lfsr", lfsr, 5'h0B);
        chk("frz_fsk", fsk_out, 0);
        chk("frz_shift", shift, 0);
        en = 1'b1;
        tick(1);
        chk("res_count", count, 51);
        chk("res_ready", ready, 1);
        tick(4);
        chk("res_fsk55", fsk_out, 0);
        tick(1);
        chk("res_fsk56", fsk_out, 1);
        tick(72);
        m = 5'h01;
        repeat (7) m = nxt(m);
        chk("seq7", lfsr, m);
        distinct = 0;
        for (int i = 0; i < 31; i++) begin
            tick(128);
            m = nxt(m);
            chk("seq_loop", lfsr, m);
            if (i == 23) chk("period_01", lfsr, 5'h01);
            if (lfsr != 5'd0 && !seen[lfsr]) distinct++;
            seen[lfsr] = 1'b1;
        end
        chk("distinct", distinct, 31);
        tick(30);
        #2 rstb = 1'b0;
        #1;
        chk("arst_lfsr", lfsr, 5'h01);
        chk("arst_count", count, 0);
        chk("arst_shift", shift, 0);
        chk("arst_ready", ready, 0);
        chk("arst_fsk", fsk_out, 0);
        tick(1);
        rstb = 1'b1;
        tick(1);
        chk("arel_ready", ready, 1);
        chk("arel_count", count, 1);
        tick(99);
        chk("lz_count", count, 100);
        force dut.lfsr = 5'd0;
        tick(1);
        release dut.lfsr;
        chk("lz_zero", lfsr, 5'd0);
        tick(26);
        chk("lz_hold", lfsr, 5'd0);
        chk("lz_c127", count, 127);
        tick(1);
        chk("lz_seed", lfsr, 5'h01);
        chk("lz_shift", shift, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
